// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder load/store responder.
// The optional error path is enabled by defining DMEM_ERR_EN.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_t;

  localparam int WAIT_CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    dmem_size_t  size;
    logic [63:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store port between the core (master) and the memory responder (slave).
// Request and response each use an independent valid/ready handshake.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_mask.sv
// Byte-enable, alignment and shift for one access, shared by store merge and load extraction.
// Enables and shift always use the size-aligned lane; 'aligned' reports whether the raw lane was.
module dmem_lane_mask
  import dmem_pkg::*;
(
  input  dmem_size_t size,
  input  logic [2:0] lane,
  output logic [7:0] byte_en,
  output logic       aligned,
  output logic [5:0] shift
);

  logic [2:0] low_bits;
  logic [7:0] base_en;
  logic [2:0] lane_a;

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    low_bits = 3'b000;
    base_en  = 8'h01;
    case (size)
      SZ_B: begin low_bits = 3'b000; base_en = 8'h01; end
      SZ_H: begin low_bits = 3'b001; base_en = 8'h03; end
      SZ_W: begin low_bits = 3'b011; base_en = 8'h0F; end
      SZ_D: begin low_bits = 3'b111; base_en = 8'hFF; end
      default: ;
    endcase
    lane_a  = lane & ~low_bits;
    aligned = (lane & low_bits) == 3'b000;
    byte_en = base_en << lane_a;
    shift   = {lane_a, 3'b000};
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then a response.
// Define DMEM_ERR_EN to report misaligned / out-of-range accesses; otherwise addresses align and wrap.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  output logic [63:0] element1,
  output logic [63:0] element2,
  output logic [63:0] element3,
  output logic [63:0] element4,
  output logic [63:0] element5,
  output logic [63:0] element6,
  output logic [63:0] element7,
  output logic [63:0] element8
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  dmem_state_t           state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  dmem_req_t             req_q, req_cur;
  logic [63:0]           mem [DEPTH];

  logic                  accept, exec, rsp_done;
  logic [7:0]            byte_en;
  logic                  lane_aligned;
  logic [5:0]            shift;
  logic [63:0]           bit_mask;
  logic [IDX_W-1:0]      word_idx;
  logic                  req_err;
  logic [63:0]           load_data, store_data;

  logic                  rsp_valid_q, rsp_err_q;
  logic [63:0]           rsp_rdata_q;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    exec       = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.req_valid) begin
        accept = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_next = ST_RESP;
          exec       = 1'b1;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: if (wait_cnt == '0) begin
        state_next = ST_RESP;
        exec       = 1'b1;
      end
      ST_RESP: if (bus.rsp_ready) begin
        state_next = ST_IDLE;
        rsp_done   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      req_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
        req_q    <= req_cur;
      end else if (state == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // With no wait states the access executes on the accept edge, straight from the bus.
  always_comb begin
    if (state == ST_IDLE) begin
      req_cur = '{we:    bus.req_we,
                  addr:  bus.req_addr,
                  size:  dmem_size_t'(bus.req_size),
                  wdata: bus.req_wdata};
    end else begin
      req_cur = req_q;
    end
  end

  dmem_lane_mask u_lane_mask (
    .size    (req_cur.size),
    .lane    (req_cur.addr[2:0]),
    .byte_en (byte_en),
    .aligned (lane_aligned),
    .shift   (shift)
  );

  assign word_idx = req_cur.addr[IDX_W+2:3];

`ifdef DMEM_ERR_EN
  assign req_err = !lane_aligned || (req_cur.addr >= 64'(DEPTH) * 64'd8);
`else
  assign req_err = 1'b0;
  // Alignment flag and high address bits only matter to the error build.
  logic unused_bits;
  assign unused_bits = ^{lane_aligned, req_cur.addr[63:IDX_W+3]};
`endif

  always_comb begin
    for (int b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{byte_en[b]}};
    end
  end

  assign load_data  = (mem[word_idx] & bit_mask) >> shift;
  assign store_data = (mem[word_idx] & ~bit_mask) | ((req_cur.wdata << shift) & bit_mask);

  // NOTE: the array must read zero after reset, so it is a cleared register file, not a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (exec && req_cur.we && !req_err) begin
      mem[word_idx] <= store_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (exec) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= req_err;
      rsp_rdata_q <= (req_cur.we || req_err) ? '0 : load_data;
    end else if (rsp_done) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign element1 = mem[0];
  assign element2 = mem[1];
  assign element3 = mem[2];
  assign element4 = mem[3];
  assign element5 = mem[4];
  assign element6 = mem[5];
  assign element7 = mem[6];
  assign element8 = mem[7];

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (WAIT_CYCLES 0, 2, 15) against a byte-array model.
// Expectations follow DMEM_ERR_EN when it is defined for the build.
module tb_dmem_responder;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 8;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  int          sel;

  logic             rdy_a   [3];
  logic             vld_a   [3];
  logic             err_a   [3];
  logic [63:0]      rdata_a [3];
  logic [7:0][63:0] el      [3];

  logic        cur_ready, cur_valid, cur_err;
  logic [63:0] cur_rdata;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  vec_t vecs[$];
  logic [7:0] mdl [3][NBYTES];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    dmem_if           bus ();
    logic [7:0][63:0] elems;

    assign bus.req_valid = req_valid && (sel == g);
    assign bus.req_we    = req_we;
    assign bus.req_addr  = req_addr;
    assign bus.req_size  = req_size;
    assign bus.req_wdata = req_wdata;
    assign bus.rsp_ready = rsp_ready && (sel == g);
    assign rdy_a[g]      = bus.req_ready;
    assign vld_a[g]      = bus.rsp_valid;
    assign err_a[g]      = bus.rsp_err;
    assign rdata_a[g]    = bus.rsp_rdata;
    assign el[g]         = elems;

    dmem_responder #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 2 : 15))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .element1 (elems[0]),
      .element2 (elems[1]),
      .element3 (elems[2]),
      .element4 (elems[3]),
      .element5 (elems[4]),
      .element6 (elems[5]),
      .element7 (elems[6]),
      .element8 (elems[7])
    );
  end

  always_comb begin
    cur_ready = rdy_a[sel];
    cur_valid = vld_a[sel];
    cur_err   = err_a[sel];
    cur_rdata = rdata_a[sel];
  end

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 2 : 15);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < NBYTES; b++)
        mdl[s][b] = 8'h00;
  endtask

  // Byte-wise reference: applies a store or computes load data and the error flag.
  task automatic model_access(input int inst, input logic we, input logic [63:0] addr,
                              input logic [1:0] size, input logic [63:0] wdata,
                              output logic [63:0] rdata, output logic err);
    int nb, base, lane;
    nb    = 1 << size;
    rdata = '0;
`ifdef DMEM_ERR_EN
    err  = ((int'(addr[2:0]) % nb) != 0) || (addr >= 64'(NBYTES));
    base = int'(addr[8:0]);
`else
    err  = 1'b0;
    lane = int'(addr[2:0]) & ~(nb - 1);
    base = int'(addr[8:3]) * 8 + lane;
`endif
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (we) mdl[inst][base + i] = wdata[8*i +: 8];
        else    rdata[8*i +: 8]     = mdl[inst][base + i];
      end
    end
  endtask

  function automatic logic [63:0] model_word(input int inst, input int w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mdl[inst][w*8 + i];
    return v;
  endfunction

  // One full transaction on the selected instance; 'hold' cycles of rsp_ready=0 with a
  // competing request presented while the response is pending.
  task automatic run_txn(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input int hold);
    int          lat;
    logic [63:0] held;
    exp_t        e;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    lat = 0;
    while (!cur_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!cur_ready) begin
      check("req_ready_timeout", 64'(cur_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_rdata, exp_err});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!cur_valid && lat < 40) begin
      check("req_ready_busy", 64'(cur_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    if (!cur_valid) begin
      check("rsp_valid_timeout", 64'(cur_valid), 64'd1);
      void'(sb.pop_front());
      rsp_ready = 1'b0;
      return;
    end
    check("latency_cycles", 64'(lat + 1), 64'(wait_of(sel) + 1));
    held = cur_rdata;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      check("hold_rsp_valid", 64'(cur_valid), 64'd1);
      check("hold_rdata_stable", cur_rdata, held);
      check("hold_req_ready_low", 64'(cur_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    e = sb.pop_front();
    check("rsp_valid_at_handshake", 64'(cur_valid), 64'd1);
    check("rsp_rdata", cur_rdata, e.rdata);
    check("rsp_err", 64'(cur_err), 64'(e.err));
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid_low", 64'(cur_valid), 64'd0);
    check("post_req_ready_high", 64'(cur_ready), 64'd1);
  endtask

  task automatic add_vec(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic err, input int hold);
    vecs.push_back('{we, addr, size, wdata, rdata, err, hold});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] m_rdata;
    logic        m_err;
    logic        saw;
    vec_t        v;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    sel       = 1;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      check("reset_req_ready", 64'(rdy_a[s]), 64'd1);
      check("reset_rsp_valid", 64'(vld_a[s]), 64'd0);
      check("reset_rsp_rdata", rdata_a[s], 64'd0);
      check("reset_rsp_err", 64'(err_a[s]), 64'd0);
      for (int k = 0; k < 8; k++) check("reset_element", el[s][k], 64'd0);
    end

    // Directed vectors on the WAIT_CYCLES=2 instance.
    add_vec(1, 64'h08,  3, 64'h1122334455667788, 64'h0, 0, 0);
    add_vec(1, 64'h0B,  0, 64'h00000000000000AB, 64'h0, 0, 0);
    add_vec(0, 64'h08,  2, 64'h0, 64'h00000000AB667788, 0, 0);
    add_vec(0, 64'h0E,  1, 64'h0, 64'h0000000000001122, 0, 5);
    add_vec(0, 64'h08,  3, 64'h0, 64'h11223344AB667788, 0, 0);
    add_vec(1, 64'h12,  1, 64'h000000000000BEEF, 64'h0, 0, 1);
    add_vec(0, 64'h10,  3, 64'h0, 64'h00000000BEEF0000, 0, 0);
    add_vec(1, 64'h20,  0, 64'hFFFFFFFFFFFFFF5A, 64'h0, 0, 0);
    add_vec(0, 64'h20,  3, 64'h0, 64'h000000000000005A, 0, 0);
    add_vec(1, 64'h1F8, 3, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 0);
    add_vec(0, 64'h1FC, 2, 64'h0, 64'h00000000DEADBEEF, 0, 2);
    add_vec(1, 64'h00,  3, 64'h0102030405060708, 64'h0, 0, 0);
`ifdef DMEM_ERR_EN
    add_vec(1, 64'h06,  2, 64'h00000000A1B2C3D4, 64'h0, 1, 0);
    add_vec(0, 64'h00,  3, 64'h0, 64'h0102030405060708, 0, 0);
    add_vec(0, 64'h200, 3, 64'h0, 64'h0, 1, 0);
    add_vec(0, 64'h01,  1, 64'h0, 64'h0, 1, 0);
`else
    add_vec(1, 64'h06,  2, 64'h00000000A1B2C3D4, 64'h0, 0, 0);
    add_vec(0, 64'h00,  3, 64'h0, 64'hA1B2C3D405060708, 0, 0);
    add_vec(0, 64'h200, 3, 64'h0, 64'hA1B2C3D405060708, 0, 0);
    add_vec(0, 64'h01,  1, 64'h0, 64'h0000000000000708, 0, 0);
`endif

    sel = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      model_access(1, v.we, v.addr, v.size, v.wdata, m_rdata, m_err);
      run_txn(v.we, v.addr, v.size, v.wdata, v.rdata, v.err, v.hold);
      if (i == 0) check("element2_after_store", el[1][1], 64'h1122334455667788);
    end

    // Reset while a store waits: the store must never commit or respond.
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 64'h10;
    req_size  = 2'd3;
    req_wdata = 64'h5555666677778888;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    check("abort_ready_before", 64'(cur_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", 64'(cur_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cur_valid) saw = 1'b1;
    end
    check("abort_no_response", 64'(saw), 64'd0);
    check("abort_element3", el[1][2], 64'd0);
    check("abort_element1_cleared", el[1][0], 64'd0);
    check("abort_ready_after", 64'(cur_ready), 64'd1);
    rsp_ready = 1'b0;
    model_clear();

    // Random sweep on every instance, expectations from the byte model.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 24; n++) begin
        logic        r_we;
        logic [1:0]  r_size;
        logic [63:0] r_addr, r_wdata;
        int          r_hold;
        r_we    = ($urandom_range(0, 2) != 0);
        r_size  = 2'($urandom_range(0, 3));
        r_addr  = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 1023))
                                              : 64'($urandom_range(0, 79));
        r_wdata = {$urandom, $urandom};
        r_hold  = $urandom_range(0, 2);
        model_access(s, r_we, r_addr, r_size, r_wdata, m_rdata, m_err);
        run_txn(r_we, r_addr, r_size, r_wdata, m_rdata, m_err, r_hold);
      end
      for (int k = 0; k < 8; k++) check("sweep_element", el[s][k], model_word(s, k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
